axi_stream_rr_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one downstream AXI-Stream datapath (register slice / consumer) between N upstream AXI-Stream requesters.
- Grants one requester at a time and holds the grant until that requester's tlast beat is accepted.
- Sits in front of the stream register stage so several sources can feed one sink without interleaving packets.

---
 rtl/axi_stream_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_axi_stream_rr_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_rr_arbiter.sv
// axi_stream_rr_arbiter
//   Packet-level round-robin arbiter: N AXI-Stream requesters share one sink.
//   An owner keeps the datapath until its tlast beat is accepted. One IDLE
//   cycle separates packets while the next owner is chosen.
//   Optional macro ARB_PKT_CNT_EN adds pkt_cnt, one 16-bit packet counter
//   per requester.

`ifdef ARB_PKT_CNT_EN
// Per-requester packet counter. It wraps naturally at 16'hFFFF.
module arb_pkt_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] cnt
);
  // Count accepted tlast beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (inc) cnt <= cnt + 16'd1;
  end
endmodule
`endif

module axi_stream_rr_arbiter #(
  parameter int DW = 8,
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*DW-1:0] s_tdata,
  input  logic [N-1:0]    s_tvalid,
  input  logic [N-1:0]    s_tlast,
  output logic [N-1:0]    s_tready,
  output logic [DW-1:0]   m_tdata,
  output logic            m_tvalid,
  output logic            m_tlast,
  input  logic            m_tready,
  output logic [N-1:0]    grant,
`ifdef ARB_PKT_CNT_EN
  output logic [16*N-1:0] pkt_cnt,
`endif
  output logic            busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        grant_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       last_q, last_d;
  logic [IW-1:0]       pick_idx;
  logic                pick_vld;
  logic                xfer;
  logic [N-1:0][DW-1:0] s_data_a;

  assign s_data_a = s_tdata;
  assign busy     = (state_q == LOCK);
  assign xfer     = m_tvalid && m_tready;

  // Pick the first valid requester searching cyclically from last_q+1.
  // Scanning from farthest to nearest lets the nearest candidate win.
  always_comb begin
    int t;
    t        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = N; k >= 1; k--) begin
      t = int'(last_q) + k;
      if (t >= N) t = t - N;
      if (s_tvalid[t]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(t);
      end
    end
  end

  // Owner mux. Outputs stay quiet in IDLE, and non-owners never reach the sink.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q == LOCK) begin
      m_tdata            = s_data_a[owner_q];
      m_tvalid           = s_tvalid[owner_q];
      m_tlast            = s_tlast[owner_q];
      s_tready[owner_q]  = m_tready;
    end
  end

  // Next-state logic. The lock is released only by an accepted tlast beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d           = LOCK;
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      LOCK: begin
        if (xfer && m_tlast) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. last_q resets to N-1 so port 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant   <= '0;
      owner_q <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_PKT_CNT_EN
  logic [N-1:0] cnt_inc;
  assign cnt_inc = (xfer && m_tlast) ? grant : '0;

  arb_pkt_cnt u_cnt [N-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .cnt   (pkt_cnt)
  );
`endif

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Directed testbench for axi_stream_rr_arbiter (N=4, DW=8).
// Inputs change just after the falling edge. Outputs are sampled 1ns later,
// so every rising edge sees stable inputs.
module tb_axi_stream_rr_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;

  logic            clk;
  logic            rst_n;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef ARB_PKT_CNT_EN
  logic [16*N-1:0] pkt_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  axi_stream_rr_arbiter #(.DW(DW), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .grant    (grant),
`ifdef ARB_PKT_CNT_EN
    .pkt_cnt  (pkt_cnt),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle: wait for the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    rst_n    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    s_tvalid = 4'b1111;
    s_tdata  = 32'hDEADBEEF;
    s_tlast  = 4'b1111;
    m_tready = 1'b1;
    step(); #1;
    n_chk++; if ({grant, busy, s_tready, m_tvalid, m_tlast, m_tdata} !== 19'd0)
      $display("FAIL reset_outputs: got %h want 0", {grant, busy, s_tready, m_tvalid, m_tlast, m_tdata}); else n_pass++;
    apply_reset();
  endtask

  task automatic test_single_packet();
    apply_reset();
    s_tvalid = 4'b0100; s_tdata[2*DW +: DW] = 8'h11; s_tlast = 4'b0000; #1;
    n_chk++; if (grant !== 4'b0000 || m_tvalid !== 1'b0)
      $display("FAIL single_idle: got grant=%b mv=%b want 0000/0", grant, m_tvalid); else n_pass++;
    step(); #1;
    n_chk++; if (grant !== 4'b0100 || busy !== 1'b1 || s_tready !== 4'b0100)
      $display("FAIL single_grant: got %b/%b/%b want 0100/1/0100", grant, busy, s_tready); else n_pass++;
    n_chk++; if (m_tdata !== 8'h11 || m_tvalid !== 1'b1)
      $display("FAIL single_beat0: got %h want 11", m_tdata); else n_pass++;
    step(); s_tdata[2*DW +: DW] = 8'h22; #1;
    n_chk++; if (m_tdata !== 8'h22 || m_tlast !== 1'b0)
      $display("FAIL single_beat1: got %h want 22", m_tdata); else n_pass++;
    step(); s_tdata[2*DW +: DW] = 8'h33; s_tlast = 4'b0100; #1;
    n_chk++; if (m_tdata !== 8'h33 || m_tlast !== 1'b1)
      $display("FAIL single_beat2: got %h/%b want 33/1", m_tdata, m_tlast); else n_pass++;
    step(); s_tvalid = '0; s_tlast = '0; #1;
    n_chk++; if (grant !== 4'b0000 || busy !== 1'b0 || m_tvalid !== 1'b0)
      $display("FAIL single_release: got %b/%b want 0000/0", grant, busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    apply_reset();
    for (int i = 0; i < N; i++) s_tdata[i*DW +: DW] = 8'hB0 + 8'(i);
    s_tvalid = 4'b1111; s_tlast = 4'b1111; #1;
    for (int k = 0; k < 5; k++) begin
      eg = 4'(1 << (k % 4));
      ed = 8'hB0 + 8'(k % 4);
      step(); #1;
      n_chk++; if (grant !== eg || m_tdata !== ed || s_tready !== eg)
        $display("FAIL rr_grant%0d: got %b/%h want %b/%h", k, grant, m_tdata, eg, ed); else n_pass++;
      step(); #1;
      n_chk++; if (grant !== 4'b0000 || m_tvalid !== 1'b0)
        $display("FAIL rr_idle%0d: got %b want 0000", k, grant); else n_pass++;
    end
    s_tvalid = '0; s_tlast = '0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    s_tdata[0 +: DW]  = 8'hA0;
    s_tdata[DW +: DW] = 8'h55;
    s_tvalid = 4'b0011; s_tlast = 4'b0010; m_tready = 1'b1;
    step(); #1;
    n_chk++; if (grant !== 4'b0001 || m_tdata !== 8'hA0)
      $display("FAIL bp_grant: got %b/%h want 0001/a0", grant, m_tdata); else n_pass++;
    step(); s_tdata[0 +: DW] = 8'hA1; m_tready = 1'b0; #1;
    n_chk++; if (m_tdata !== 8'hA1 || s_tready !== 4'b0000 || m_tvalid !== 1'b1)
      $display("FAIL bp_stall0: got %h/%b want a1/0000", m_tdata, s_tready); else n_pass++;
    step(); #1;
    n_chk++; if (m_tdata !== 8'hA1 || grant !== 4'b0001)
      $display("FAIL bp_stall1: got %h/%b want a1/0001", m_tdata, grant); else n_pass++;
    step(); m_tready = 1'b1; #1;
    n_chk++; if (m_tdata !== 8'hA1 || s_tready !== 4'b0001)
      $display("FAIL bp_resume: got %h/%b want a1/0001", m_tdata, s_tready); else n_pass++;
    step(); s_tdata[0 +: DW] = 8'hA2; #1;
    step(); s_tdata[0 +: DW] = 8'hA3; s_tlast = 4'b0011; #1;
    n_chk++; if (m_tdata !== 8'hA3 || m_tlast !== 1'b1 || grant !== 4'b0001)
      $display("FAIL bp_last: got %h/%b/%b want a3/1/0001", m_tdata, m_tlast, grant); else n_pass++;
    step(); s_tvalid = 4'b0010; s_tlast = 4'b0010; #1;
    n_chk++; if (grant !== 4'b0000)
      $display("FAIL bp_idle: got %b want 0000", grant); else n_pass++;
    step(); #1;
    n_chk++; if (grant !== 4'b0010 || m_tdata !== 8'h55)
      $display("FAIL bp_next: got %b/%h want 0010/55", grant, m_tdata); else n_pass++;
    step(); s_tvalid = '0; s_tlast = '0;
  endtask

  task automatic test_owner_gap();
    apply_reset();
    s_tdata[DW +: DW]   = 8'h61;
    s_tdata[3*DW +: DW] = 8'h77;
    s_tvalid = 4'b1010; s_tlast = 4'b1000; m_tready = 1'b1;
    step(); #1;
    n_chk++; if (grant !== 4'b0010 || m_tdata !== 8'h61)
      $display("FAIL gap_grant: got %b/%h want 0010/61", grant, m_tdata); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      step(); s_tvalid = 4'b1000; #1;
      n_chk++; if (grant !== 4'b0010 || m_tvalid !== 1'b0 || s_tready[3] !== 1'b0)
        $display("FAIL gap_hold%0d: got %b/%b/%b want 0010/0/0", c, grant, m_tvalid, s_tready[3]); else n_pass++;
    end
    step(); s_tvalid = 4'b1010; s_tdata[DW +: DW] = 8'h62; s_tlast = 4'b1010; #1;
    n_chk++; if (m_tdata !== 8'h62 || m_tvalid !== 1'b1 || m_tlast !== 1'b1)
      $display("FAIL gap_resume: got %h/%b want 62/1", m_tdata, m_tvalid); else n_pass++;
    step(); s_tvalid = 4'b1000; #1;
    step(); #1;
    n_chk++; if (grant !== 4'b1000 || m_tdata !== 8'h77)
      $display("FAIL gap_next: got %b/%h want 1000/77", grant, m_tdata); else n_pass++;
    step(); s_tvalid = '0; s_tlast = '0;
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    s_tdata[3*DW +: DW] = 8'h31;
    s_tdata[0 +: DW]    = 8'h01;
    s_tvalid = 4'b1000; s_tlast = 4'b0000; m_tready = 1'b1;
    step(); #1;
    n_chk++; if (grant !== 4'b1000)
      $display("FAIL rst_mid_grant: got %b want 1000", grant); else n_pass++;
    step(); s_tvalid = 4'b1001; #1;
    rst_n = 1'b0; #1;
    n_chk++; if (grant !== 4'b0000 || m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 4'b0000)
      $display("FAIL rst_mid_async: got %b/%b/%b want 0000/0/0", grant, m_tvalid, busy); else n_pass++;
    step(); rst_n = 1'b1; #1;
    n_chk++; if (grant !== 4'b0000)
      $display("FAIL rst_mid_idle: got %b want 0000", grant); else n_pass++;
    step(); #1;
    n_chk++; if (grant !== 4'b0001 || m_tdata !== 8'h01)
      $display("FAIL rst_mid_prio: got %b/%h want 0001/01", grant, m_tdata); else n_pass++;
    s_tvalid = '0;
  endtask

`ifdef ARB_PKT_CNT_EN
  task automatic test_pkt_cnt();
    apply_reset();
    s_tdata[DW +: DW] = 8'h5A; s_tlast = 4'b0010; m_tready = 1'b1;
    s_tvalid = 4'b0010;
    for (int p = 0; p < 5; p++) begin
      step();
      step();
    end
    s_tvalid = '0; #1;
    n_chk++; if (pkt_cnt !== 64'h0000_0000_0005_0000)
      $display("FAIL pkt_cnt: got %h want 0000000000050000", pkt_cnt); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_owner_gap();
    test_reset_mid_packet();
`ifdef ARB_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
